rect_filler: RTL and testbench

- Parametrised successor to the full-screen filler. Rasterises an axis-aligned rectangle, clipped to the screen, into a valid/ready pixel stream for the framebuffer writer.
- Supports solid fill and a two-colour checkerboard mode.
- Adds abort, last-pixel marking and a completion pulse.
- Sits between the command decoder and the pixel arbiter in the renderer.

---
 rtl/rect_filler.sv | 119 +++++++++++
 tb/tb_rect_filler.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_filler.sv
// rect_filler: rasterises a screen-clipped rectangle (solid or checkerboard) into a valid/ready pixel stream
module rect_filler #(
    parameter int WIDTH   = 320,
    parameter int HEIGHT  = 240,
    parameter int COORD_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic signed [COORD_W-1:0] cmd_x0,
    input  logic signed [COORD_W-1:0] cmd_y0,
    input  logic signed [COORD_W-1:0] cmd_x1,
    input  logic signed [COORD_W-1:0] cmd_y1,
    input  logic [11:0]               cmd_color_a,
    input  logic [11:0]               cmd_color_b,
    input  logic                      cmd_mode,
    input  logic [3:0]                cmd_cell_log2,
    input  logic                      abort,
    output logic [COORD_W-1:0]        out_pixel_x,
    output logic [COORD_W-1:0]        out_pixel_y,
    output logic [15:0]               out_color,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      done
);
    typedef enum logic [1:0] {IDLE, CLIP, RUN} state_t;
    localparam logic signed [COORD_W-1:0] XMAX = COORD_W'(WIDTH - 1);
    localparam logic signed [COORD_W-1:0] YMAX = COORD_W'(HEIGHT - 1);

    state_t                    state_q;
    logic signed [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
    logic signed [COORD_W-1:0] cx0_d, cy0_d, cx1_d, cy1_d;
    logic [COORD_W-1:0]        cx0_q, cx1_q, cy1_q, x_q, y_q, xy;
    logic [COORD_W-1:0]        out_x_q, out_y_q;
    logic [15:0]               color_a_q, color_b_q, color_d, out_color_q;
    logic [3:0]                n_q;
    logic                      mode_q, empty_d, can_emit, at_last, row_end;
    logic                      out_valid_q, out_last_q, done_q;

    function automatic logic [15:0] to565(input logic [11:0] c);
        return {c[11:8], c[11], c[7:4], c[7:6], c[3:0], c[3]};
    endfunction

    always_comb begin
        cx0_d    = (x0_q < 0) ? '0 : x0_q;
        cy0_d    = (y0_q < 0) ? '0 : y0_q;
        cx1_d    = (x1_q > XMAX) ? XMAX : x1_q;
        cy1_d    = (y1_q > YMAX) ? YMAX : y1_q;
        empty_d  = (x0_q > x1_q) || (y0_q > y1_q) || (cx0_d > cx1_d) || (cy0_d > cy1_d);
        can_emit = !out_valid_q || out_ready;
        row_end  = (x_q == cx1_q);
        at_last  = row_end && (y_q == cy1_q);
        xy       = x_q ^ y_q;
        color_d  = (mode_q && xy[n_q]) ? color_b_q : color_a_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            {x0_q, y0_q, x1_q, y1_q} <= '0;
            {cx0_q, cx1_q, cy1_q, x_q, y_q} <= '0;
            {color_a_q, color_b_q, mode_q, n_q} <= '0;
            {out_x_q, out_y_q, out_color_q} <= '0;
            {out_valid_q, out_last_q, done_q} <= '0;
        end else begin
            done_q <= out_valid_q && out_ready && out_last_q;
            if (out_valid_q && out_ready)
                out_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (cmd_valid) begin
                    {x0_q, y0_q, x1_q, y1_q} <= {cmd_x0, cmd_y0, cmd_x1, cmd_y1};
                    color_a_q <= to565(cmd_color_a);
                    color_b_q <= to565(cmd_color_b);
                    mode_q    <= cmd_mode;
                    n_q       <= cmd_cell_log2;
                    state_q   <= CLIP;
                end
                CLIP: if (abort || empty_d) begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end else begin
                    cx0_q   <= cx0_d;
                    cx1_q   <= cx1_d;
                    cy1_q   <= cy1_d;
                    x_q     <= cx0_d;
                    y_q     <= cy0_d;
                    state_q <= RUN;
                end
                RUN: if (abort && !(can_emit && at_last)) begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end else if (can_emit) begin
                    out_x_q     <= x_q;
                    out_y_q     <= y_q;
                    out_color_q <= color_d;
                    out_last_q  <= at_last;
                    out_valid_q <= 1'b1;
                    x_q         <= row_end ? cx0_q : x_q + 1'b1;
                    y_q         <= row_end ? y_q + 1'b1 : y_q;
                    if (at_last)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE) || out_valid_q;
    assign done        = done_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign out_pixel_x = out_x_q;
    assign out_pixel_y = out_y_q;
    assign out_color   = out_color_q;
endmodule

// File: tb/tb_rect_filler.sv
// tb_rect_filler: randomized scenario bench for rect_filler against a raster-list reference model
module tb_rect_filler;
    localparam int W = 8, H = 4, CW = 16;

    logic clk = 0, rst = 1, cmd_valid = 0, cmd_mode = 0, abort = 0, out_ready = 1;
    logic [CW-1:0] cmd_x0 = 0, cmd_y0 = 0, cmd_x1 = 0, cmd_y1 = 0;
    logic [11:0] cmd_color_a = 0, cmd_color_b = 0;
    logic [3:0] cmd_cell_log2 = 0;
    logic cmd_ready, out_last, out_valid, busy, done;
    logic [CW-1:0] out_pixel_x, out_pixel_y;
    logic [15:0] out_color;

    rect_filler #(.WIDTH(W), .HEIGHT(H), .COORD_W(CW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
        .cmd_color_a(cmd_color_a), .cmd_color_b(cmd_color_b), .cmd_mode(cmd_mode),
        .cmd_cell_log2(cmd_cell_log2), .abort(abort), .out_pixel_x(out_pixel_x),
        .out_pixel_y(out_pixel_y), .out_color(out_color), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        logic [15:0] c;
        logic last;
    } pix_t;

    pix_t exp_q[$];
    int checks = 0, failures = 0;

    function automatic logic [15:0] rgb565(input logic [11:0] c);
        int r, g, b;
        r = int'(c[11:8]);
        g = int'(c[7:4]);
        b = int'(c[3:0]);
        return 16'((r * 2 + r / 8) * 2048 + (g * 4 + g / 4) * 32 + (b * 2 + b / 8));
    endfunction

    task automatic model(input int x0, input int y0, input int x1, input int y1,
                         input logic [11:0] ca, input logic [11:0] cb, input logic m, input int n);
        int cx0, cy0, cx1, cy1;
        pix_t p;
        cx0 = x0 < 0 ? 0 : x0;
        cy0 = y0 < 0 ? 0 : y0;
        cx1 = x1 > W - 1 ? W - 1 : x1;
        cy1 = y1 > H - 1 ? H - 1 : y1;
        if (x0 > x1 || y0 > y1 || cx0 > cx1 || cy0 > cy1) return;
        for (int y = cy0; y <= cy1; y++)
            for (int x = cx0; x <= cx1; x++) begin
                p.x = x;
                p.y = y;
                p.c = (m && ((((x >> n) ^ (y >> n)) & 1) == 1)) ? rgb565(cb) : rgb565(ca);
                p.last = (x == cx1) && (y == cy1);
                exp_q.push_back(p);
            end
    endtask

    task automatic issue(input int x0, input int y0, input int x1, input int y1,
                         input logic [11:0] ca, input logic [11:0] cb, input logic m, input logic [3:0] n);
        cmd_x0 = 16'(x0);
        cmd_y0 = 16'(y0);
        cmd_x1 = 16'(x1);
        cmd_y1 = 16'(y1);
        cmd_color_a = ca;
        cmd_color_b = cb;
        cmd_mode = m;
        cmd_cell_log2 = n;
        cmd_valid = 1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL issue_cmd_ready got=%b want=1", cmd_ready);
        end
        @(posedge clk);
        #1 cmd_valid = 0;
    endtask

    task automatic drain(input string name, input bit rnd, input int ndone, output int first_v,
                         output int first_x, output int last_x, output int done_at);
        bit stall = 0;
        logic [CW-1:0] sx = 0, sy = 0;
        logic [15:0] sc = 0;
        logic sl = 0;
        int dones = 0;
        pix_t p;
        first_v = -1; first_x = -1; last_x = -1; done_at = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (stall) begin
                checks++;
                if ({out_valid, out_pixel_x, out_pixel_y, out_color, out_last} !== {1'b1, sx, sy, sc, sl}) begin
                    failures++;
                    $display("FAIL %s_stable got=(%0d,%0d) %h l%b v%b want=(%0d,%0d) %h l%b v1",
                             name, out_pixel_x, out_pixel_y, out_color, out_last, out_valid, sx, sy, sc, sl);
                end
            end
            if (done) begin dones++; done_at = i; end
            if (out_valid && first_v < 0) first_v = i;
            if (exp_q.size() != 0) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_busy got=%b want=1 cycle=%0d", name, busy, i);
                end
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s_extra got=(%0d,%0d) want=none", name, out_pixel_x, out_pixel_y);
                end else begin
                    p = exp_q.pop_front();
                    if (out_pixel_x !== 16'(p.x) || out_pixel_y !== 16'(p.y) || out_color !== p.c || out_last !== p.last) begin
                        failures++;
                        $display("FAIL %s_pixel got=(%0d,%0d) %h l%b want=(%0d,%0d) %h l%b",
                                 name, out_pixel_x, out_pixel_y, out_color, out_last, p.x, p.y, p.c, p.last);
                    end
                end
                if (first_x < 0) first_x = i;
                last_x = i;
            end
            stall = out_valid && !out_ready;
            {sx, sy, sc, sl} = {out_pixel_x, out_pixel_y, out_color, out_last};
            if (exp_q.size() == 0 && dones >= ndone && !out_valid) break;
        end
        checks++;
        if (exp_q.size() != 0 || dones != ndone) begin
            failures++;
            $display("FAIL %s_complete got left=%0d dones=%0d want left=0 dones=%0d", name, exp_q.size(), dones, ndone);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle_busy got=%b want=0", name, busy);
        end
        exp_q.delete();
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if ({out_valid, out_last, done, busy, cmd_ready, out_pixel_x, out_pixel_y, out_color} !== {5'b00001, 48'd0}) begin
            failures++;
            $display("FAIL reset got v%b l%b d%b b%b r%b (%0d,%0d) %h want v0 l0 d0 b0 r1 (0,0) 0000",
                     out_valid, out_last, done, busy, cmd_ready, out_pixel_x, out_pixel_y, out_color);
        end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_full;
        int fv, fx, lx, da;
        model(0, 0, 7, 3, 12'hF80, 12'h000, 0, 0);
        issue(0, 0, 7, 3, 12'hF80, 12'h000, 0, 0);
        drain("full", 0, 1, fv, fx, lx, da);
        checks++;
        if (fv != 2) begin failures++; $display("FAIL full_latency got=%0d want=2", fv); end
        checks++;
        if (lx - fx != 31) begin failures++; $display("FAIL full_throughput got=%0d want=31", lx - fx); end
        checks++;
        if (da != lx + 1) begin failures++; $display("FAIL full_done_timing got=%0d want=%0d", da, lx + 1); end
    endtask

    task automatic test_clip;
        int fv, fx, lx, da;
        model(-3, -2, 2, 10, 12'h5A3, 12'h000, 0, 0);
        checks++;
        if (exp_q.size() != 12) begin failures++; $display("FAIL clip_model_count got=%0d want=12", exp_q.size()); end
        issue(-3, -2, 2, 10, 12'h5A3, 12'h000, 0, 0);
        drain("clip", 0, 1, fv, fx, lx, da);
    endtask

    task automatic test_empty;
        int fv, fx, lx, da;
        issue(5, 1, 4, 3, 12'hFFF, 12'h000, 0, 0);
        drain("empty_inv", 0, 1, fv, fx, lx, da);
        checks++;
        if (da != 1) begin failures++; $display("FAIL empty_inv_done got=%0d want=1", da); end
        issue(9, 0, 12, 3, 12'hFFF, 12'h000, 0, 0);
        drain("empty_off", 0, 1, fv, fx, lx, da);
        checks++;
        if (da != 1) begin failures++; $display("FAIL empty_off_done got=%0d want=1", da); end
    endtask

    task automatic test_checker;
        int fv, fx, lx, da;
        model(0, 0, 3, 1, 12'h000, 12'hFFF, 1, 1);
        issue(0, 0, 3, 1, 12'h000, 12'hFFF, 1, 1);
        drain("checker", 0, 1, fv, fx, lx, da);
    endtask

    task automatic test_stall;
        int fv, fx, lx, da;
        model(2, 1, 5, 3, 12'h3C7, 12'h000, 0, 0);
        issue(2, 1, 5, 3, 12'h3C7, 12'h000, 0, 0);
        drain("stall", 1, 1, fv, fx, lx, da);
    endtask

    task automatic test_random;
        int fv, fx, lx, da, x0, y0, x1, y1, n;
        logic [11:0] ca, cb;
        logic m;
        for (int k = 0; k < 10; k++) begin
            x0 = int'($urandom_range(0, 15)) - 4;
            x1 = int'($urandom_range(0, 15)) - 4;
            y0 = int'($urandom_range(0, 9)) - 3;
            y1 = int'($urandom_range(0, 9)) - 3;
            n = int'($urandom_range(0, 3));
            m = 1'($urandom_range(0, 1));
            ca = 12'($urandom);
            cb = 12'($urandom);
            model(x0, y0, x1, y1, ca, cb, m, n);
            issue(x0, y0, x1, y1, ca, cb, m, 4'(n));
            drain("random", 1, 1, fv, fx, lx, da);
        end
    endtask

    task automatic test_back_to_back;
        int fv, fx, lx, da;
        bit seen = 0;
        pix_t p;
        out_ready = 0;
        issue(3, 2, 3, 2, 12'h123, 12'h000, 0, 0);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        checks++;
        if (!seen || cmd_ready !== 1'b1 || out_last !== 1'b1) begin
            failures++;
            $display("FAIL b2b_pending got v%b r%b l%b want v1 r1 l1", out_valid, cmd_ready, out_last);
        end
        issue(0, 0, 1, 0, 12'hABC, 12'h000, 0, 0);
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, out_pixel_x, out_pixel_y, out_color, out_last} !== {1'b1, 16'd3, 16'd2, rgb565(12'h123), 1'b1}) begin
            failures++;
            $display("FAIL b2b_hold got v%b (%0d,%0d) %h l%b want v1 (3,2) %h l1",
                     out_valid, out_pixel_x, out_pixel_y, out_color, out_last, rgb565(12'h123));
        end
        p.x = 3; p.y = 2; p.c = rgb565(12'h123); p.last = 1;
        exp_q.push_back(p);
        model(0, 0, 1, 0, 12'hABC, 12'h000, 0, 0);
        drain("b2b", 0, 2, fv, fx, lx, da);
    endtask

    task automatic test_abort;
        int n = 0, further = 0, dseen = 0;
        bit ab = 0;
        out_ready = 1;
        issue(0, 0, 7, 3, 12'h0F0, 12'h000, 0, 0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            abort = 0;
            if (done) dseen++;
            if (out_valid) begin
                if (ab) begin
                    further++;
                    checks++;
                    if (out_last !== 1'b0) begin failures++; $display("FAIL abort_last got=%b want=0", out_last); end
                end else begin
                    n++;
                    if (n == 5) begin abort = 1; ab = 1; end
                end
            end
            if (ab && dseen > 0 && !out_valid) break;
        end
        abort = 0;
        checks++;
        if (further > 1) begin failures++; $display("FAIL abort_further got=%0d want<=1", further); end
        checks++;
        if (dseen != 1) begin failures++; $display("FAIL abort_done got=%0d want=1", dseen); end
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle got r%b b%b want r1 b0", cmd_ready, busy);
        end
    endtask

    task automatic test_reset_mid;
        bit bad = 0;
        out_ready = 1;
        issue(0, 0, 7, 3, 12'hF0F, 12'h000, 0, 0);
        repeat (6) @(negedge clk);
        #2 rst = 1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid got v%b b%b r%b want v0 b0 r1", out_valid, busy, cmd_ready);
        end
        #1 rst = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid || done) bad = 1;
        end
        checks++;
        if (bad) begin failures++; $display("FAIL rst_after got activity=1 want=0"); end
    endtask

    initial begin
        test_reset;
        test_full;
        test_clip;
        test_empty;
        test_checker;
        test_stall;
        test_random;
        test_back_to_back;
        test_abort;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
